// File: rtl/dff_pkg.sv
// Shared constants, state encodings and byte-lane merge helper for the dff
// register-file slave.
package dff_pkg;

    localparam int         NUM_REGS_DEFAULT = 4;
    localparam logic [1:0] RESP_OKAY        = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ADDR_OK = 2'd1,
        WR_DATA_OK = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dff.sv
// AXI-Lite slave exposing NUM_REGS word-indexed 32-bit registers; one outstanding
// write, independent read path, every output registered.
module dff
    import dff_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cbus_awaddr,
    input  logic [2:0]              cbus_awprot,
    input  logic                    cbus_awvalid,
    output logic                    cbus_awready,
    input  logic [DATA_WIDTH-1:0]   cbus_wdata,
    input  logic [DATA_WIDTH/8-1:0] cbus_wstrb,
    input  logic                    cbus_wvalid,
    output logic                    cbus_wready,
    output logic [1:0]              cbus_bresp,
    output logic                    cbus_bvalid,
    input  logic                    cbus_bready,
    input  logic [ADDR_WIDTH-1:0]   cbus_araddr,
    input  logic [2:0]              cbus_arprot,
    input  logic                    cbus_arvalid,
    output logic                    cbus_arready,
    output logic [DATA_WIDTH-1:0]   cbus_rdata,
    output logic [1:0]              cbus_rresp,
    output logic                    cbus_rvalid,
    input  logic                    cbus_rready
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic unused_prot;
    assign unused_prot = ^{cbus_awprot, cbus_arprot};

    wr_state_t                 wr_state_q, wr_state_d;
    rd_state_t                 rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];

    logic aw_hs, w_hs, ar_hs;
    logic aw_mapped, ar_mapped;

    assign aw_hs     = cbus_awvalid && awready_q;
    assign w_hs      = cbus_wvalid && wready_q;
    assign ar_hs     = cbus_arvalid && arready_q;
    assign aw_mapped = (awaddr_q[ADDR_WIDTH-1:IDX_W] == '0);
    assign ar_mapped = (cbus_araddr[ADDR_WIDTH-1:IDX_W] == '0);

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;

        if (aw_hs) awaddr_d = cbus_awaddr;
        if (w_hs) begin
            wdata_d = cbus_wdata;
            wstrb_d = cbus_wstrb;
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_RESP;
                else if (aw_hs)    wr_state_d = WR_ADDR_OK;
                else if (w_hs)     wr_state_d = WR_DATA_OK;
            end
            WR_ADDR_OK: if (w_hs)  wr_state_d = WR_RESP;
            WR_DATA_OK: if (aw_hs) wr_state_d = WR_RESP;
            WR_RESP: begin
                // First cycle in RESP commits the write; later cycles wait for bready.
                if (!bvalid_q) begin
                    if (aw_mapped) begin
                        regs_d[awaddr_q[IDX_W-1:0]] =
                            apply_wstrb(regs_q[awaddr_q[IDX_W-1:0]], wdata_q, wstrb_q);
                    end
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end else if (cbus_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_DATA_OK);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_ADDR_OK);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d    = ar_mapped ? regs_q[cbus_araddr[IDX_W-1:0]] : '0;
                    rresp_d    = RESP_OKAY;
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (cbus_rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    assign cbus_awready = awready_q;
    assign cbus_wready  = wready_q;
    assign cbus_bvalid  = bvalid_q;
    assign cbus_bresp   = bresp_q;
    assign cbus_arready = arready_q;
    assign cbus_rvalid  = rvalid_q;
    assign cbus_rdata   = rdata_q;
    assign cbus_rresp   = rresp_q;

endmodule

// File: tb/tb_dff.sv
// Randomised self-checking bench for the dff AXI-Lite register file.
module tb_dff;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cbus_awaddr;
    logic [2:0]  cbus_awprot;
    logic        cbus_awvalid;
    logic        cbus_awready;
    logic [31:0] cbus_wdata;
    logic [3:0]  cbus_wstrb;
    logic        cbus_wvalid;
    logic        cbus_wready;
    logic [1:0]  cbus_bresp;
    logic        cbus_bvalid;
    logic        cbus_bready;
    logic [31:0] cbus_araddr;
    logic [2:0]  cbus_arprot;
    logic        cbus_arvalid;
    logic        cbus_arready;
    logic [31:0] cbus_rdata;
    logic [1:0]  cbus_rresp;
    logic        cbus_rvalid;
    logic        cbus_rready;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    dff #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .cbus_awaddr(cbus_awaddr), .cbus_awprot(cbus_awprot),
        .cbus_awvalid(cbus_awvalid), .cbus_awready(cbus_awready),
        .cbus_wdata(cbus_wdata), .cbus_wstrb(cbus_wstrb),
        .cbus_wvalid(cbus_wvalid), .cbus_wready(cbus_wready),
        .cbus_bresp(cbus_bresp), .cbus_bvalid(cbus_bvalid), .cbus_bready(cbus_bready),
        .cbus_araddr(cbus_araddr), .cbus_arprot(cbus_arprot),
        .cbus_arvalid(cbus_arvalid), .cbus_arready(cbus_arready),
        .cbus_rdata(cbus_rdata), .cbus_rresp(cbus_rresp),
        .cbus_rvalid(cbus_rvalid), .cbus_rready(cbus_rready)
    );

    // Reference: a word array; strobe turns into a byte mask.
    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (a < 32'd4) model[a] = (model[a] & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a < 32'd4) ? model[a] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic to, output logic [1:0] resp);
        logic aw_done, w_done, aw_hit, w_hit;
        int   n;
        aw_done = 1'b0; w_done = 1'b0; n = 0; to = 1'b0;
        cbus_awaddr = a; cbus_wdata = d; cbus_wstrb = s;
        cbus_awvalid = 1'b1; cbus_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hit = cbus_awvalid && cbus_awready;
            w_hit  = cbus_wvalid && cbus_wready;
            @(posedge clk); #1; n++;
            if (aw_hit) begin aw_done = 1'b1; cbus_awvalid = 1'b0; end
            if (w_hit)  begin w_done  = 1'b1; cbus_wvalid  = 1'b0; end
        end
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        n = 0;
        while (!cbus_bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!cbus_bvalid || !aw_done || !w_done) to = 1'b1;
        resp = cbus_bresp;
        cbus_bready = 1'b1;
        @(posedge clk); #1;
        cbus_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic to,
                            output logic [31:0] data, output logic [1:0] resp);
        logic hit;
        int   n;
        n = 0; to = 1'b0; hit = 1'b0;
        cbus_araddr = a; cbus_arvalid = 1'b1;
        while (!hit && n < 50) begin
            hit = cbus_arready;
            @(posedge clk); #1; n++;
        end
        cbus_arvalid = 1'b0;
        n = 0;
        while (!cbus_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!cbus_rvalid || !hit) to = 1'b1;
        data = cbus_rdata; resp = cbus_rresp;
        cbus_rready = 1'b1;
        @(posedge clk); #1;
        cbus_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic to; logic [31:0] d; logic [1:0] r;
        rst = 1'b1;
        cbus_awaddr = '0; cbus_awprot = '0; cbus_awvalid = 0; cbus_wdata = '0;
        cbus_wstrb = '0; cbus_wvalid = 0; cbus_bready = 0; cbus_araddr = '0;
        cbus_arprot = '0; cbus_arvalid = 0; cbus_rready = 0;
        model_clear();
        #100;
        n_vec++;
        if ({cbus_awready, cbus_wready, cbus_arready, cbus_bvalid, cbus_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {cbus_awready, cbus_wready, cbus_arready, cbus_bvalid, cbus_rvalid});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({cbus_awready, cbus_wready, cbus_arready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 111",
                     {cbus_awready, cbus_wready, cbus_arready});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(i, to, d, r);
            n_vec++;
            if (to !== 1'b0 || d !== 32'h0 || r !== 2'b00) begin
                n_err++;
                $display("FAIL reset_read%0d: got data=%h resp=%b to=%b expected 0/00/0", i, d, r, to);
            end
        end
    endtask

    task automatic test_full_write();
        logic to; logic [31:0] d; logic [1:0] r;
        for (int i = 0; i < 4; i++) begin
            axi_write(i, 32'hFFFF_FFFF, 4'hF, to, r);
            model_write(i, 32'hFFFF_FFFF, 4'hF);
            n_vec++;
            if (to !== 1'b0 || r !== 2'b00) begin
                n_err++;
                $display("FAIL full_write%0d: got bresp=%b to=%b expected 00/0", i, r, to);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(i, to, d, r);
            n_vec++;
            if (to !== 1'b0 || d !== 32'hFFFF_FFFF || r !== 2'b00) begin
                n_err++;
                $display("FAIL full_read%0d: got %h resp=%b to=%b expected ffffffff", i, d, r, to);
            end
        end
    endtask

    task automatic test_partial_strobe();
        logic to; logic [31:0] d; logic [1:0] r;
        axi_write(1, 32'h0, 4'hF, to, r);
        model_write(1, 32'h0, 4'hF);
        axi_write(1, 32'hAABB_CCDD, 4'b0101, to, r);
        model_write(1, 32'hAABB_CCDD, 4'b0101);
        axi_read(1, to, d, r);
        n_vec++;
        if (to !== 1'b0 || d !== model_read(1) || d !== 32'h00BB_00DD) begin
            n_err++;
            $display("FAIL partial_strobe: got %h to=%b expected %h", d, to, model_read(1));
        end
    endtask

    task automatic test_w_before_aw();
        logic to; logic [31:0] d; logic [1:0] r; int n;
        cbus_wdata = 32'hCAFE_F00D; cbus_wstrb = 4'hF; cbus_wvalid = 1'b1;
        @(posedge clk); #1; cbus_wvalid = 1'b0;
        repeat (3) begin
            n_vec++;
            if ({cbus_bvalid, cbus_awready, cbus_wready} !== 3'b010) begin
                n_err++;
                $display("FAIL w_only_wait: got bvalid/awready/wready=%b expected 010",
                         {cbus_bvalid, cbus_awready, cbus_wready});
            end
            @(posedge clk); #1;
        end
        cbus_awaddr = 32'd2; cbus_awvalid = 1'b1;
        @(posedge clk); #1; cbus_awvalid = 1'b0;
        model_write(2, 32'hCAFE_F00D, 4'hF);
        n = 0;
        while (!cbus_bvalid && n < 20) begin @(posedge clk); #1; n++; end
        n_vec++;
        if (cbus_bvalid !== 1'b1 || cbus_bresp !== 2'b00) begin
            n_err++;
            $display("FAIL w_first_bvalid: got bvalid=%b bresp=%b expected 1/00", cbus_bvalid, cbus_bresp);
        end
        cbus_awaddr = 32'd0; cbus_awvalid = 1'b1;
        cbus_wdata = 32'h0BAD_0BAD; cbus_wvalid = 1'b1;
        repeat (5) begin
            n_vec++;
            if ({cbus_bvalid, cbus_awready, cbus_wready} !== 3'b100) begin
                n_err++;
                $display("FAIL bresp_hold: got bvalid/awready/wready=%b expected 100",
                         {cbus_bvalid, cbus_awready, cbus_wready});
            end
            @(posedge clk); #1;
        end
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        cbus_bready = 1'b1;
        @(posedge clk); #1; cbus_bready = 1'b0;
        repeat (3) begin
            n_vec++;
            if (cbus_bvalid !== 1'b0) begin
                n_err++;
                $display("FAIL single_bvalid: got bvalid=%b expected 0", cbus_bvalid);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i += 2) begin
            axi_read(i, to, d, r);
            n_vec++;
            if (to !== 1'b0 || d !== model_read(i)) begin
                n_err++;
                $display("FAIL w_first_read%0d: got %h to=%b expected %h", i, d, to, model_read(i));
            end
        end
    endtask

    task automatic test_unmapped();
        logic to; logic [31:0] d; logic [1:0] r;
        axi_write(32'h10, 32'h1234_5678, 4'hF, to, r);
        model_write(32'h10, 32'h1234_5678, 4'hF);
        n_vec++;
        if (to !== 1'b0 || r !== 2'b00) begin
            n_err++;
            $display("FAIL unmapped_bresp: got %b to=%b expected 00", r, to);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(i, to, d, r);
            n_vec++;
            if (to !== 1'b0 || d !== model_read(i)) begin
                n_err++;
                $display("FAIL unmapped_regs%0d: got %h expected %h", i, d, model_read(i));
            end
        end
        axi_read(32'h10, to, d, r);
        n_vec++;
        if (to !== 1'b0 || d !== 32'h0 || r !== 2'b00) begin
            n_err++;
            $display("FAIL unmapped_read: got %h resp=%b expected 0/00", d, r);
        end
    endtask

    task automatic test_read_hold();
        logic to; logic [31:0] d; logic [1:0] r; logic [31:0] v; int n;
        v = $urandom;
        axi_write(3, v, 4'hF, to, r);
        model_write(3, v, 4'hF);
        cbus_araddr = 32'd3; cbus_arvalid = 1'b1;
        @(posedge clk); #1; cbus_arvalid = 1'b0;
        n = 0;
        while (!cbus_rvalid && n < 20) begin @(posedge clk); #1; n++; end
        repeat (4) begin
            n_vec++;
            if (cbus_rvalid !== 1'b1 || cbus_rdata !== model_read(3) || cbus_arready !== 1'b0) begin
                n_err++;
                $display("FAIL read_hold: got rvalid=%b rdata=%h arready=%b expected 1/%h/0",
                         cbus_rvalid, cbus_rdata, cbus_arready, model_read(3));
            end
            @(posedge clk); #1;
        end
        cbus_rready = 1'b1;
        @(posedge clk); #1; cbus_rready = 1'b0;
        n_vec++;
        if (cbus_rvalid !== 1'b0 || cbus_arready !== 1'b1) begin
            n_err++;
            $display("FAIL read_release: got rvalid=%b arready=%b expected 0/1", cbus_rvalid, cbus_arready);
        end
    endtask

    task automatic test_concurrent();
        logic to; logic [31:0] d; logic [1:0] r;
        axi_write(3, 32'h1111_1111, 4'hF, to, r);
        model_write(3, 32'h1111_1111, 4'hF);
        cbus_awaddr = 32'd3; cbus_wdata = 32'h2222_2222; cbus_wstrb = 4'hF;
        cbus_awvalid = 1'b1; cbus_wvalid = 1'b1;
        @(posedge clk); #1;
        cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
        cbus_araddr = 32'd3; cbus_arvalid = 1'b1;
        @(posedge clk); #1; cbus_arvalid = 1'b0;
        n_vec++;
        if (cbus_rvalid !== 1'b1 || cbus_rdata !== model_read(3) || cbus_bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL concurrent_prewrite: got rvalid=%b rdata=%h bvalid=%b expected 1/%h/1",
                     cbus_rvalid, cbus_rdata, cbus_bvalid, model_read(3));
        end
        cbus_rready = 1'b1; cbus_bready = 1'b1;
        @(posedge clk); #1; cbus_rready = 1'b0; cbus_bready = 1'b0;
        model_write(3, 32'h2222_2222, 4'hF);
        axi_read(3, to, d, r);
        n_vec++;
        if (to !== 1'b0 || d !== model_read(3)) begin
            n_err++;
            $display("FAIL concurrent_postwrite: got %h expected %h", d, model_read(3));
        end
    endtask

    task automatic test_reset_mid_write();
        logic to; logic [31:0] d; logic [1:0] r; int n;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cbus_awaddr = 32'd1; cbus_awvalid = 1'b1;
        @(posedge clk); #1; cbus_awvalid = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({cbus_awready, cbus_wready, cbus_arready, cbus_bvalid} !== 4'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b expected 0000",
                     {cbus_awready, cbus_wready, cbus_arready, cbus_bvalid});
        end
        cbus_wdata = 32'hDEAD_BEEF; cbus_wstrb = 4'hF; cbus_wvalid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        cbus_wvalid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (cbus_bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_bvalid: got %b expected 0", cbus_bvalid);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(i, to, d, r);
            n_vec++;
            if (to !== 1'b0 || d !== 32'h0) begin
                n_err++;
                $display("FAIL reset_mid_reg%0d: got %h expected 0", i, d);
            end
        end
        cbus_wdata = 32'h5A5A_A5A5; cbus_wvalid = 1'b1;
        @(posedge clk); #1; cbus_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (cbus_bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_aw_latch: got bvalid=%b expected 0", cbus_bvalid);
        end
        cbus_awaddr = 32'd0; cbus_awvalid = 1'b1;
        @(posedge clk); #1; cbus_awvalid = 1'b0;
        n = 0;
        while (!cbus_bvalid && n < 20) begin @(posedge clk); #1; n++; end
        cbus_bready = 1'b1; @(posedge clk); #1; cbus_bready = 1'b0;
        model_write(0, 32'h5A5A_A5A5, 4'hF);
        axi_read(0, to, d, r);
        n_vec++;
        if (to !== 1'b0 || d !== model_read(0)) begin
            n_err++;
            $display("FAIL post_reset_write: got %h expected %h", d, model_read(0));
        end
    endtask

    task automatic test_random();
        logic to; logic [31:0] a, d, q; logic [3:0] s; logic [1:0] r;
        for (int k = 0; k < 40; k++) begin
            a = $urandom_range(0, 5);
            if (a >= 32'd4) a = 32'd4 << $urandom_range(0, 27);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, to, r);
                model_write(a, d, s);
                n_vec++;
                if (to !== 1'b0 || r !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_write a=%h: got bresp=%b to=%b expected 00/0", a, r, to);
                end
            end else begin
                axi_read(a, to, q, r);
                n_vec++;
                if (to !== 1'b0 || q !== model_read(a) || r !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_read a=%h: got %h resp=%b to=%b expected %h",
                             a, q, r, to, model_read(a));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_write();
        test_partial_strobe();
        test_w_before_aw();
        test_unmapped();
        test_read_hold();
        test_concurrent();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
